muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle integer multiply/divide unit with its own sequencing FSM, attached beside the ALU in the execute stage. When the execute stage presents a MUL/DIV-class instruction, the block captures the already-forwarded operands, iterates one bit per cycle, and holds the pipeline stall line high until the result is ready. On completion it returns one word for the execute-stage result mux. Flush from branch resolution aborts an in-flight operation.

## Interface
- WORD_LEN, 32: operand/result width; iteration count equals WORD_LEN.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  execute stage holds a mul/div instruction; sampled only in IDLE.
- op  in  2  00 MUL (low word of product), 01 MULHU (high word, unsigned), 10 DIVU (quotient), 11 REMU (remainder).
- opA  in  WORD_LEN  first operand, post-forwarding (multiplicand / dividend).
- opB  in  WORD_LEN  second operand, post-forwarding (multiplier / divisor).
- flush  in  1  abort current operation.
- stall  out  1  freeze IF/ID/EXE registers; combinational.
- busy  out  1  registered; high in RUN.
- done  out  1  one-cycle pulse; result valid.
- result  out  WORD_LEN  registered; holds last completed value.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If start & !flush: latch opA, opB, op; load counter = WORD_LEN; go to RUN.
  - If op is DIVU/REMU and opB == 0: go to DONE directly. Result is 0xFFFFFFFF for DIVU, opA for REMU.
- RUN, multiply:
  - 2·WORD_LEN product register {hi, lo}, lo initialised to opB, hi to 0.
  - Each cycle: if lo[0], hi += opA with carry; then shift {carry, hi, lo} right 1.
- RUN, divide (restoring):
  - Remainder R = 0, quotient Q = opA.
  - Each cycle: shift {R, Q} left 1. If R ≥ opB (WORD_LEN+1-bit compare), R -= opB and Q[0] = 1.
- RUN: counter decrements each cycle. When the counter reaches 1, move to DONE on the next edge.
- DONE:
  - result selected per op: MUL lo, MULHU hi, DIVU Q, REMU R.
  - Result is written at entry to DONE; done = 1.
  - Go to IDLE unconditionally. start is ignored in DONE, because the same instruction is still in EXE.
- stall = (IDLE & start & !flush) | RUN. Low in DONE, so the pipeline advances and EXE captures result that cycle.
- flush:
  - In RUN, or in IDLE with start: next state IDLE, stall = 0 that cycle, no done, result unchanged.
  - flush has priority over start.
  - flush during DONE is ignored; the result has already been produced.
- All arithmetic is unsigned, modulo 2^WORD_LEN per word. MUL low word is also correct for signed operands.

## Timing
- Reset values: state IDLE, stall 0 (given start = 0), busy 0, done 0, result 0, counter 0.
- rst mid-operation: IDLE on the next edge, no done pulse, result cleared to 0.
- Normal latency (start accepted at cycle 0):
  - RUN occupies cycles 1..WORD_LEN.
  - DONE is cycle WORD_LEN+1 (33); done high and stall low there.
  - stall is high for cycles 0..WORD_LEN (33 cycles).
- Divide by zero: DONE at cycle 1; stall high only in cycle 0.
- Back-to-back instructions:
  - The next instruction reaches EXE in cycle WORD_LEN+2.
  - Its start is accepted in IDLE in that cycle; there is no dead cycle beyond the DONE cycle.
- Operands are sampled only at the acceptance edge. Changes on opA/opB during RUN have no effect.

## Test plan
- MUL 7 × 6:
  - done pulses at cycle 33 with result 42.
  - stall high for cycles 0–32, low at 33.
  - busy high for cycles 1–32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE at cycle 33.
- MUL of the same operands → result 0x00000001.
- DIVU 100 / 7 → result 14. REMU 100 / 7 → result 2. Both at cycle 33.
- DIVU 0x1234 / 0 → result 0xFFFFFFFF at cycle 1.
- REMU 0x1234 / 0 → result 0x00001234 at cycle 1.
- Both divide-by-zero cases: stall high only in cycle 0.
- Start MUL 5 × 5, then assert flush at RUN cycle 10:
  - IDLE next cycle, stall low in the flush cycle.
  - No done; result retains its previous value.
- Start DIVU, assert rst at cycle 15:
  - Next cycle: IDLE, busy 0, stall 0, result 0, no done.
- Back-to-back MUL 3 × 4 then DIVU 9 / 2:
  - First done at cycle 33 with result 12.
  - Second start accepted at cycle 34; second done at cycle 67 with result 4.
  - start held high in cycle 33 is not accepted.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle unsigned integer multiply/divide unit for the execute stage.
// Operands are captured when a MUL/DIV-class instruction is accepted in IDLE.
// The unit then iterates one bit per cycle for WORD_LEN cycles and returns one
// word on the cycle it pulses done. A flush from branch resolution aborts an
// in-flight operation without producing a result.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-high reset
//   start   in   execute stage holds a mul/div instruction (sampled in IDLE)
//   op      in   00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   opA     in   multiplicand / dividend (post-forwarding)
//   opB     in   multiplier / divisor (post-forwarding)
//   flush   in   abort the current operation
//   stall   out  freeze IF/ID/EXE registers (combinational)
//   busy    out  registered, high while iterating
//   done    out  registered one-cycle pulse, result valid
//   result  out  registered, holds the last completed value
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [WORD_LEN-1:0] opA,
    input  logic [WORD_LEN-1:0] opB,
    input  logic                flush,
    output logic                stall,
    output logic                busy,
    output logic                done,
    output logic [WORD_LEN-1:0] result
);

    localparam int CNT_W = $clog2(WORD_LEN + 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Pick the architectural result out of the shared {hi, lo} datapath.
    // Multiply keeps the product in {hi, lo}; divide keeps R in hi and Q in lo.
    function automatic logic [WORD_LEN-1:0] result_sel(
        input logic [1:0]          sel,
        input logic [WORD_LEN-1:0] hi,
        input logic [WORD_LEN-1:0] lo
    );
        logic [WORD_LEN-1:0] r;
        case (sel)
            OP_MUL:   r = lo;
            OP_MULHU: r = hi;
            OP_DIVU:  r = lo;
            OP_REMU:  r = hi;
            default:  r = lo;
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [WORD_LEN-1:0] a_q, a_d;
    logic [WORD_LEN-1:0] b_q, b_d;
    logic [WORD_LEN-1:0] hi_q, hi_d;
    logic [WORD_LEN-1:0] lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_LEN-1:0] result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // One-iteration step values for both algorithms
    logic [WORD_LEN:0]   mul_sum_s;
    logic [WORD_LEN-1:0] mul_hi_s;
    logic [WORD_LEN-1:0] mul_lo_s;
    logic [WORD_LEN:0]   div_sh_s;
    logic                div_ge_s;
    logic [WORD_LEN-1:0] div_r_s;
    logic [WORD_LEN-1:0] div_q_s;
    logic [WORD_LEN-1:0] step_hi_s;
    logic [WORD_LEN-1:0] step_lo_s;

    // Single shift-add / restoring-divide iteration on the current {hi, lo}.
    always_comb begin
        mul_sum_s = {1'b0, hi_q};
        if (lo_q[0]) begin
            mul_sum_s = {1'b0, hi_q} + {1'b0, a_q};
        end else begin
            mul_sum_s = {1'b0, hi_q};
        end
        // Shift {carry, hi, lo} right by one.
        mul_hi_s = mul_sum_s[WORD_LEN:1];
        mul_lo_s = {mul_sum_s[0], lo_q[WORD_LEN-1:1]};

        // Shift {R, Q} left by one; the compare needs the bit shifted out of R.
        div_sh_s = {hi_q, lo_q[WORD_LEN-1]};
        div_ge_s = (div_sh_s >= {1'b0, b_q});
        if (div_ge_s) begin
            // The difference is below the divisor, so it fits in WORD_LEN bits.
            div_r_s = div_sh_s[WORD_LEN-1:0] - b_q;
        end else begin
            div_r_s = div_sh_s[WORD_LEN-1:0];
        end
        div_q_s = {lo_q[WORD_LEN-2:0], div_ge_s};

        if (op_q[1]) begin
            step_hi_s = div_r_s;
            step_lo_s = div_q_s;
        end else begin
            step_hi_s = mul_hi_s;
            step_lo_s = mul_lo_s;
        end
    end

    // Next-state, datapath load and stall decode.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        stall    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    stall = 1'b1;
                    op_d  = op;
                    a_d   = opA;
                    b_d   = opB;
                    if (op[1] && (opB == {WORD_LEN{1'b0}})) begin
                        // Divide by zero skips iteration entirely.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        if (op == OP_DIVU) begin
                            result_d = {WORD_LEN{1'b1}};
                        end else begin
                            result_d = opA;
                        end
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(WORD_LEN);
                        hi_d    = {WORD_LEN{1'b0}};
                        if (op[1]) begin
                            lo_d = opA;
                        end else begin
                            lo_d = opB;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (flush) begin
                    // Abort: pipeline is released this cycle, result untouched.
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    hi_d  = step_hi_s;
                    lo_d  = step_lo_s;
                    if (cnt_q == CNT_W'(1)) begin
                        // Last iteration: result is written as DONE is entered.
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = result_sel(op_q, step_hi_s, step_lo_s);
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_DONE: begin
                // The instruction that produced the result is still in EXE,
                // so start is not looked at here and flush has nothing to undo.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            a_q      <= {WORD_LEN{1'b0}};
            b_q      <= {WORD_LEN{1'b0}};
            hi_q     <= {WORD_LEN{1'b0}};
            lo_q     <= {WORD_LEN{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            result_q <= {WORD_LEN{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed bench for muldiv_sequencer. Stimulus pushes the expected result and
// the expected done cycle into a scoreboard queue; an independent monitor pops
// and compares whenever done is seen. Stall/busy are checked cycle by cycle
// from the stimulus side.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    muldiv_sequencer #(.WORD_LEN(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_result", result, e.res);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one instruction (called #1 after a posedge), check stall/busy every
    // cycle up to done, optionally present the next instruction during DONE.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int lat, input bit chain,
                          input logic [1:0] no, input logic [W-1:0] na, input logic [W-1:0] nb);
        int c0;
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        c0    = cyc;
        sb.push_back(exp_t'{exp, c0 + lat});
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk("stall", {31'd0, stall}, {31'd0, (k < lat)});
            chk("busy", {31'd0, busy}, {31'd0, (k >= 1 && k < lat)});
            @(posedge clk);
            #1;
            if (k == 0) begin
                // Operands wander after acceptance; they must not matter.
                start = 1'b0;
                opA   = ~a;
                opB   = b ^ 32'h5a5a_0001;
            end
            if (chain && k == lat - 1) begin
                start = 1'b1;
                op    = no;
                opA   = na;
                opB   = nb;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        opA   = 32'd0;
        opB   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk);
        #1;

        run_op(OP_MUL,   32'd7,         32'd6,         32'd42,        LAT, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(OP_DIVU,  32'd100,       32'd7,         32'd14,        LAT, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(OP_REMU,  32'd100,       32'd7,         32'd2,         LAT, 1'b0, 2'b00, 32'd0, 32'd0);
        run_op(OP_DIVU,  32'h1234,      32'd0,         32'hFFFF_FFFF, 1,   1'b0, 2'b00, 32'd0, 32'd0);
        run_op(OP_REMU,  32'h1234,      32'd0,         32'h0000_1234, 1,   1'b0, 2'b00, 32'd0, 32'd0);

        // Flush MUL 5x5 in RUN cycle 10; result must keep 0x1234.
        start = 1'b1;
        op    = OP_MUL;
        opA   = 32'd5;
        opB   = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_busy", {31'd0, busy}, 32'd0);
        chk("post_flush_stall", {31'd0, stall}, 32'd0);
        chk("post_flush_result", result, 32'h0000_1234);
        repeat (40) @(posedge clk);
        #1;

        // Reset during DIVU at cycle 15.
        start = 1'b1;
        op    = OP_DIVU;
        opA   = 32'h0000_1000;
        opB   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        // Back-to-back: start held through DONE, accepted the cycle after.
        run_op(OP_MUL,  32'd3, 32'd4, 32'd12, LAT, 1'b1, OP_DIVU, 32'd9, 32'd2);
        run_op(OP_DIVU, 32'd9, 32'd2, 32'd4,  LAT, 1'b0, 2'b00,   32'd0, 32'd0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
